// File: rtl/eeprom_i2c_responder.sv
// Two-wire serial EEPROM slave: oversamples SCL/SDA on CLK, decodes START/STOP and bytes, serves writes/reads.
// Latency: ~3 CLK behind bus edges; mem_we one CLK after the 8th data rise; no backpressure (bus-timed).
module eeprom_i2c_responder #(
  parameter logic [3:0] DEV_CODE = 4'b1010,
  parameter int         ADDR_W   = 11
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              SCL,
  inout  wire               SDA,
  output logic              busy,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata
);

  localparam int HI_W = ADDR_W - 8;

  typedef enum logic [3:0] {
    IDLE, CTRL, CTRL_ACK, ADDR, ADDR_ACK, WDATA, WDATA_ACK, RDATA, RACK, WAIT_STOP
  } state_t;

  state_t            state, state_d;
  logic [1:0]        scl_sync, sda_sync;
  logic              scl_q, sda_q;
  logic [3:0]        cnt, cnt_d;
  logic [7:0]        shreg, shreg_d;
  logic              ack_ph, ack_ph_d;
  logic              rw, rw_d;
  logic [HI_W-1:0]   ctrl_hi, ctrl_hi_d;
  logic [ADDR_W-1:0] pointer, pointer_d;
  logic              sda_oe, sda_oe_d;
  logic              busy_d, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [7:0]        mem_wdata_d;
  logic [7:0]        mem [0:(1<<ADDR_W)-1];
  logic [7:0]        rd_byte, byte_in;
  logic              scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

  assign SDA = sda_oe ? 1'b0 : 1'bz;

  // Synchronizers reset to the idle-bus level so no spurious edge follows reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], SCL};
      sda_sync <= {sda_sync[0], SDA};
      scl_q    <= scl_sync[1];
      sda_q    <= sda_sync[1];
    end
  end

  assign scl_s     = scl_sync[1];
  assign sda_s     = sda_sync[1];
  assign scl_rise  = scl_s & ~scl_q;
  assign scl_fall  = ~scl_s & scl_q;
  assign start_det = scl_s & scl_q & sda_q & ~sda_s;
  assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;
  assign byte_in   = {shreg[6:0], sda_s};
  assign rd_byte   = mem[pointer];

  always_ff @(posedge CLK) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      cnt       <= '0;
      shreg     <= '0;
      ack_ph    <= 1'b0;
      rw        <= 1'b0;
      ctrl_hi   <= '0;
      pointer   <= '0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      shreg     <= shreg_d;
      ack_ph    <= ack_ph_d;
      rw        <= rw_d;
      ctrl_hi   <= ctrl_hi_d;
      pointer   <= pointer_d;
      sda_oe    <= sda_oe_d;
      busy      <= busy_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
    end
  end

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    shreg_d     = shreg;
    ack_ph_d    = ack_ph;
    rw_d        = rw;
    ctrl_hi_d   = ctrl_hi;
    pointer_d   = pointer;
    sda_oe_d    = sda_oe;
    busy_d      = busy;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;

    if (start_det) begin
      state_d  = CTRL;
      cnt_d    = '0;
      ack_ph_d = 1'b0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b1;
    end else if (stop_det) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state)
        IDLE, WAIT_STOP: sda_oe_d = 1'b0;

        CTRL, ADDR, WDATA: begin
          if (scl_rise) begin
            shreg_d = byte_in;
            cnt_d   = cnt + 4'd1;
            if (cnt == 4'd7) begin
              cnt_d    = '0;
              ack_ph_d = 1'b0;
              if (state == CTRL) begin
                if (byte_in[7:4] != DEV_CODE) begin
                  state_d = WAIT_STOP;
                end else begin
                  rw_d = byte_in[0];
                  if (!byte_in[0]) ctrl_hi_d = byte_in[HI_W:1];
                  state_d = CTRL_ACK;
                end
              end else if (state == ADDR) begin
                pointer_d = {ctrl_hi, byte_in};
                state_d   = ADDR_ACK;
              end else begin
                mem_we_d    = 1'b1;
                mem_wdata_d = byte_in;
                mem_addr_d  = pointer;
                state_d     = WDATA_ACK;
              end
            end
          end
        end

        // First SCL fall pulls SDA low for the ACK, the second ends the slot.
        CTRL_ACK, ADDR_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            if (!ack_ph) begin
              sda_oe_d = 1'b1;
              ack_ph_d = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              ack_ph_d = 1'b0;
              cnt_d    = '0;
              if (state == CTRL_ACK) begin
                if (rw) begin
                  shreg_d    = rd_byte;
                  sda_oe_d   = ~rd_byte[7];
                  mem_addr_d = pointer;
                  state_d    = RDATA;
                end else begin
                  state_d = ADDR;
                end
              end else if (state == ADDR_ACK) begin
                state_d = WDATA;
              end else begin
                pointer_d = pointer + ADDR_W'(1);
                state_d   = WDATA;
              end
            end
          end
        end

        RDATA: begin
          if (scl_rise) cnt_d = cnt + 4'd1;
          if (scl_fall) begin
            if (cnt == 4'd8) begin
              sda_oe_d = 1'b0;
              cnt_d    = '0;
              ack_ph_d = 1'b0;
              state_d  = RACK;
            end else begin
              sda_oe_d = ~shreg[6];
              shreg_d  = {shreg[6:0], 1'b0};
            end
          end
        end

        // Master ACK advances the pointer; the next byte is driven on the following fall.
        RACK: begin
          if (scl_rise && !ack_ph) begin
            if (sda_s) begin
              state_d = WAIT_STOP;
            end else begin
              ack_ph_d  = 1'b1;
              pointer_d = pointer + ADDR_W'(1);
            end
          end else if (scl_fall && ack_ph) begin
            shreg_d    = rd_byte;
            sda_oe_d   = ~rd_byte[7];
            mem_addr_d = pointer;
            cnt_d      = '0;
            ack_ph_d   = 1'b0;
            state_d    = RDATA;
          end
        end

        default: begin
          state_d  = IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eeprom_i2c_responder.sv
// Directed bench for eeprom_i2c_responder: bit-banged master with pull-up on SDA,
// hand-computed expectations for writes, reads, wrap, aborts and reset.
module tb_eeprom_i2c_responder;

  localparam int Q = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scl = 1'b1;
  logic        m_low = 1'b0;
  wire         sda;
  logic        busy, mem_we;
  logic [10:0] mem_addr;
  logic [7:0]  mem_wdata;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  int drove_cnt = 0;
  logic [10:0] we_addr = '0;
  logic [7:0]  we_data = '0;

  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  eeprom_i2c_responder dut (
    .CLK(clk), .RESET(rst), .SCL(scl), .SDA(sda),
    .busy(busy), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata)
  );

  always @(posedge clk) begin
    #2;
    if (mem_we === 1'b1) begin
      we_cnt  = we_cnt + 1;
      we_addr = mem_addr;
      we_data = mem_wdata;
    end
    if (!m_low && sda === 1'b0) drove_cnt = drove_cnt + 1;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_low = 1'b0; wait_clk(Q);
    scl = 1'b1;   wait_clk(Q);
    m_low = 1'b1; wait_clk(Q);
    scl = 1'b0;   wait_clk(Q);
  endtask

  task automatic i2c_stop();
    m_low = 1'b1; wait_clk(Q);
    scl = 1'b1;   wait_clk(Q);
    m_low = 1'b0; wait_clk(Q);
  endtask

  task automatic write_bit(input logic b);
    m_low = ~b; wait_clk(Q);
    scl = 1'b1; wait_clk(2*Q);
    scl = 1'b0; wait_clk(Q);
  endtask

  task automatic read_bit(output logic b);
    m_low = 1'b0; wait_clk(Q);
    scl = 1'b1;   wait_clk(Q);
    b = sda;      wait_clk(Q);
    scl = 1'b0;   wait_clk(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic nack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(nack);
  endtask

  task automatic test_reset();
    rst = 1'b1; wait_clk(5);
    rst = 1'b0; wait_clk(5);
    checks += 5;
    if (busy !== 1'b0)      begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    if (mem_we !== 1'b0)    begin errors++; $display("FAIL rst_mem_we got %b exp 0", mem_we); end
    if (mem_addr !== 11'h0) begin errors++; $display("FAIL rst_mem_addr got %h exp 000", mem_addr); end
    if (mem_wdata !== 8'h0) begin errors++; $display("FAIL rst_mem_wdata got %h exp 00", mem_wdata); end
    if (sda !== 1'b1)       begin errors++; $display("FAIL rst_sda got %b exp 1", sda); end
  endtask

  task automatic test_write();
    logic a0, a1, a2;
    int base = we_cnt;
    i2c_start();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL wr_busy_start got %b exp 1", busy); end
    write_byte(8'hA2, a0);
    write_byte(8'h23, a1);
    write_byte(8'h5A, a2);
    i2c_stop();
    wait_clk(4);
    checks += 7;
    if (a0 !== 1'b0) begin errors++; $display("FAIL wr_ack_ctrl got %b exp 0", a0); end
    if (a1 !== 1'b0) begin errors++; $display("FAIL wr_ack_addr got %b exp 0", a1); end
    if (a2 !== 1'b0) begin errors++; $display("FAIL wr_ack_data got %b exp 0", a2); end
    if (we_cnt - base !== 1) begin errors++; $display("FAIL wr_we_count got %0d exp 1", we_cnt - base); end
    if (we_addr !== 11'h123) begin errors++; $display("FAIL wr_addr got %h exp 123", we_addr); end
    if (we_data !== 8'h5A)   begin errors++; $display("FAIL wr_data got %h exp 5a", we_data); end
    if (busy !== 1'b0)       begin errors++; $display("FAIL wr_busy_stop got %b exp 0", busy); end
  endtask

  task automatic test_random_read();
    logic a0, a1, a2;
    logic [7:0] d;
    i2c_start();
    write_byte(8'hA2, a0);
    write_byte(8'h23, a1);
    i2c_start();
    write_byte(8'hA3, a2);
    read_byte(d, 1'b1);
    checks += 6;
    if (sda !== 1'b1) begin errors++; $display("FAIL rr_sda_released got %b exp 1", sda); end
    if (mem_addr !== 11'h123) begin errors++; $display("FAIL rr_mem_addr got %h exp 123", mem_addr); end
    i2c_stop();
    wait_clk(4);
    if ({a0, a1, a2} !== 3'b000) begin errors++; $display("FAIL rr_acks got %b exp 000", {a0, a1, a2}); end
    if (d !== 8'h5A)   begin errors++; $display("FAIL rr_data got %h exp 5a", d); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rr_busy got %b exp 0", busy); end
    if (sda !== 1'b1)  begin errors++; $display("FAIL rr_sda_idle got %b exp 1", sda); end
  endtask

  task automatic test_bad_device();
    logic a0;
    int base = drove_cnt;
    i2c_start();
    write_byte(8'hB2, a0);
    write_bit(1'b0);
    i2c_stop();
    wait_clk(4);
    checks += 3;
    if (a0 !== 1'b1) begin errors++; $display("FAIL bad_ack got %b exp 1", a0); end
    if (drove_cnt - base !== 0) begin errors++; $display("FAIL bad_sda_driven got %0d exp 0", drove_cnt - base); end
    if (busy !== 1'b0) begin errors++; $display("FAIL bad_busy got %b exp 0", busy); end
  endtask

  task automatic test_wrap();
    logic a0, a1, a2, a3, a4, a5, a6;
    logic [7:0] d0, d1;
    int base = we_cnt;
    i2c_start();
    write_byte(8'hAE, a0);
    write_byte(8'hFF, a1);
    write_byte(8'h11, a2);
    write_byte(8'h22, a3);
    i2c_stop();
    wait_clk(4);
    checks += 3;
    if (we_cnt - base !== 2) begin errors++; $display("FAIL wrap_we_count got %0d exp 2", we_cnt - base); end
    if (we_addr !== 11'h000) begin errors++; $display("FAIL wrap_last_addr got %h exp 000", we_addr); end
    if (we_data !== 8'h22)   begin errors++; $display("FAIL wrap_last_data got %h exp 22", we_data); end
    i2c_start();
    write_byte(8'hAE, a4);
    write_byte(8'hFF, a5);
    i2c_start();
    write_byte(8'hAF, a6);
    read_byte(d0, 1'b0);
    read_byte(d1, 1'b1);
    i2c_stop();
    wait_clk(4);
    checks += 3;
    if ({a0, a1, a2, a3, a4, a5, a6} !== 7'b0) begin
      errors++; $display("FAIL wrap_acks got %b exp 0000000", {a0, a1, a2, a3, a4, a5, a6});
    end
    if (d0 !== 8'h11) begin errors++; $display("FAIL wrap_rd_7ff got %h exp 11", d0); end
    if (d1 !== 8'h22) begin errors++; $display("FAIL wrap_rd_000 got %h exp 22", d1); end
  endtask

  task automatic test_stop_mid_byte();
    logic a0, a1, a2, a3, a4;
    int base = we_cnt;
    i2c_start();
    write_byte(8'hA2, a0);
    write_byte(8'h23, a1);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
    i2c_stop();
    wait_clk(4);
    checks += 3;
    if (we_cnt - base !== 0) begin errors++; $display("FAIL stopmid_we got %0d exp 0", we_cnt - base); end
    if (busy !== 1'b0) begin errors++; $display("FAIL stopmid_busy got %b exp 0", busy); end
    if (sda !== 1'b1)  begin errors++; $display("FAIL stopmid_sda got %b exp 1", sda); end
    i2c_start();
    write_byte(8'hA2, a2);
    write_byte(8'h23, a3);
    write_byte(8'h3C, a4);
    i2c_stop();
    wait_clk(4);
    checks += 4;
    if ({a0, a1, a2, a3, a4} !== 5'b0) begin errors++; $display("FAIL b2b_acks got %b exp 00000", {a0, a1, a2, a3, a4}); end
    if (we_cnt - base !== 1) begin errors++; $display("FAIL b2b_we_count got %0d exp 1", we_cnt - base); end
    if (we_addr !== 11'h123) begin errors++; $display("FAIL b2b_addr got %h exp 123", we_addr); end
    if (we_data !== 8'h3C)   begin errors++; $display("FAIL b2b_data got %h exp 3c", we_data); end
  endtask

  task automatic test_reset_mid_read();
    logic a0, a1, a2, a3;
    logic [7:0] d;
    i2c_start();
    write_byte(8'hA2, a0);
    write_byte(8'h23, a1);
    i2c_start();
    write_byte(8'hA3, a2);
    checks++;
    if (sda !== 1'b0) begin errors++; $display("FAIL rmid_bit7_drive got %b exp 0", sda); end
    rst = 1'b1;
    wait_clk(1);
    checks += 4;
    if (sda !== 1'b1)       begin errors++; $display("FAIL rmid_sda got %b exp 1", sda); end
    if (busy !== 1'b0)      begin errors++; $display("FAIL rmid_busy got %b exp 0", busy); end
    if (mem_addr !== 11'h0) begin errors++; $display("FAIL rmid_mem_addr got %h exp 000", mem_addr); end
    if (mem_wdata !== 8'h0) begin errors++; $display("FAIL rmid_mem_wdata got %h exp 00", mem_wdata); end
    wait_clk(4);
    rst = 1'b0;
    wait_clk(4);
    i2c_start();
    write_byte(8'hA1, a3);
    read_byte(d, 1'b1);
    i2c_stop();
    wait_clk(4);
    checks += 3;
    if ({a0, a1, a2, a3} !== 4'b0) begin errors++; $display("FAIL rmid_acks got %b exp 0000", {a0, a1, a2, a3}); end
    if (d !== 8'h22) begin errors++; $display("FAIL rmid_ptr_zero_read got %h exp 22", d); end
    if (mem_addr !== 11'h000) begin errors++; $display("FAIL rmid_read_addr got %h exp 000", mem_addr); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_random_read();
    test_bad_device();
    test_wrap();
    test_stop_mid_byte();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
